// File: rtl/ln4522_prescaler_if.sv
// Control/status bus of the ln4522 BCD prescaler. Optional sq output is present
// only when LN4522_PRESCALER_SQUARE_EN is defined.
interface ln4522_prescaler_if #(
  parameter int DIGITS = 2
);
  localparam int W = 4 * DIGITS;

  // No valid/ready handshake: inh/pe/cf/p are level controls sampled on every
  // rising cp0 edge, and q/zero/tc(/sq) are status that is always valid.
  logic         inh;
  logic         pe;
  logic         cf;
  logic [W-1:0] p;
  logic [W-1:0] q;
  logic         zero;
  logic         tc;
`ifdef LN4522_PRESCALER_SQUARE_EN
  logic         sq;

  modport master (output inh, output pe, output cf, output p,
                  input q, input zero, input tc, input sq);
  modport slave  (input inh, input pe, input cf, input p,
                  output q, output zero, output tc, output sq);
`else
  modport master (output inh, output pe, output cf, output p,
                  input q, input zero, input tc);
  modport slave  (input inh, input pe, input cf, input p,
                  output q, output zero, output tc);
`endif
endinterface

// File: rtl/ln4522_prescaler.sv
// Presettable BCD down-counter used as a divide-by-N prescaler for ln4017.
// Optional square-wave output enabled by defining LN4522_PRESCALER_SQUARE_EN.
module ln4522_prescaler #(
  parameter int DIGITS = 2
) (
  input  logic              cp0,
  input  logic              mr,
  ln4522_prescaler_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_q;
  logic         r_tc;
  logic [W-1:0] w_clamp;
  logic [W-1:0] w_dec;
  logic         w_is_zero;
  logic         w_is_one;

  // Nibbles above 9 are forced to 9 digit by digit.
  always_comb begin
    w_clamp = bus.p;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.p[4*i +: 4] > 4'd9) w_clamp[4*i +: 4] = 4'd9;
    end
  end

  always_comb begin
    logic w_borrow;
    w_dec    = r_q;
    w_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_borrow) begin
        if (r_q[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_q[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  assign w_is_zero = (r_q == '0);
  assign w_is_one  = (r_q == ONE);

`ifdef LN4522_PRESCALER_SQUARE_EN
  logic r_sq;
`endif

  always_ff @(posedge cp0) begin
    if (mr) begin
      r_q  <= '0;
      r_tc <= 1'b0;
`ifdef LN4522_PRESCALER_SQUARE_EN
      r_sq <= 1'b0;
`endif
    end else if (bus.pe) begin
      r_q  <= w_clamp;
      r_tc <= 1'b0;
    end else if (bus.inh) begin
      r_tc <= 1'b0;
    end else if (w_is_one || (w_is_zero && bus.cf)) begin
      // Terminal event: reload in divide mode, otherwise land on zero.
      r_q  <= bus.cf ? w_clamp : '0;
      r_tc <= 1'b1;
`ifdef LN4522_PRESCALER_SQUARE_EN
      r_sq <= ~r_sq;
`endif
    end else if (w_is_zero) begin
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_dec;
      r_tc <= 1'b0;
    end
  end

  assign bus.q    = r_q;
  assign bus.tc   = r_tc;
  assign bus.zero = w_is_zero;
`ifdef LN4522_PRESCALER_SQUARE_EN
  assign bus.sq   = r_sq;
`endif

endmodule

// File: tb/tb_ln4522_prescaler.sv
// Randomised and directed bench for ln4522_prescaler against an integer model.
module tb_ln4522_prescaler;
  localparam int DIGITS = 3;
  localparam int W = 4 * DIGITS;

  logic cp0;
  logic mr;
  ln4522_prescaler_if #(.DIGITS(DIGITS)) bus ();

  ln4522_prescaler #(.DIGITS(DIGITS)) dut (
    .cp0 (cp0),
    .mr  (mr),
    .bus (bus)
  );

  // clock / reset block
  initial begin
    cp0 = 1'b0;
    forever #5 cp0 = ~cp0;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  int m_q  = 0;
  bit m_tc = 1'b0;
  bit m_sq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    int s = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r += int'(v[4*i +: 4]) * s;
      s *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Preset value as a decimal number after saturating each digit at 9.
  function automatic int clamp_int(input logic [W-1:0] v);
    int r = 0;
    int s = 1;
    int d;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * s;
      s *= 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit mr_v, input bit pe_v, input bit inh_v,
                            input bit cf_v, input logic [W-1:0] p_v);
    if (mr_v) begin
      m_q = 0; m_tc = 0; m_sq = 0;
    end else if (pe_v) begin
      m_q = clamp_int(p_v); m_tc = 0;
    end else if (inh_v) begin
      m_tc = 0;
    end else if (m_q >= 2) begin
      m_q = m_q - 1; m_tc = 0;
    end else if (m_q == 1 || cf_v) begin
      m_q  = cf_v ? clamp_int(p_v) : 0;
      m_tc = 1;
      m_sq = ~m_sq;
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("q", 32'(bus.q), 32'(e));
    chk("tc", 32'(bus.tc), 32'(m_tc));
    chk("zero", 32'(bus.zero), 32'(m_q == 0));
`ifdef LN4522_PRESCALER_SQUARE_EN
    chk("sq", 32'(bus.sq), 32'(m_sq));
`endif
  endtask

  // driver: apply inputs, take one edge, update model, compare
  task automatic cycle(input bit mr_v, input bit pe_v, input bit inh_v,
                       input bit cf_v, input logic [W-1:0] p_v);
    mr      = mr_v;
    bus.pe  = pe_v;
    bus.inh = inh_v;
    bus.cf  = cf_v;
    bus.p   = p_v;
    @(posedge cp0);
    model_step(mr_v, pe_v, inh_v, cf_v, p_v);
    exp_q.push_back(int2bcd(m_q));
    #1;
    check_outputs();
  endtask

  task automatic load(input bit cf_v, input logic [W-1:0] p_v);
    cycle(1'b0, 1'b1, 1'b0, cf_v, p_v);
  endtask

  task automatic count(input int n, input bit cf_v, input logic [W-1:0] p_v,
                       output int tc_seen);
    tc_seen = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, 1'b0, cf_v, p_v);
      if (bus.tc === 1'b1) tc_seen++;
    end
  endtask

  initial begin
    int tcs;
    int sq_hi;
    logic [W-1:0] rp;
    mr = 1'b1; bus.pe = 1'b0; bus.inh = 1'b0; bus.cf = 1'b0; bus.p = '0;

    // reset with random side inputs, then reset beats preset
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, W'($urandom));
    chk("reset_q", 32'(bus.q), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, W'('h345));
    chk("reset_over_pe", 32'(bus.q), 32'h0);

    // first count edge after reset with cf=1 reloads and pulses tc
    cycle(1'b0, 1'b0, 1'b0, 1'b1, W'('h004));
    chk("first_tc", 32'(bus.tc), 32'h1);

    // divide by 12
    load(1'b1, W'('h012));
    count(24, 1'b1, W'('h012), tcs);
    chk("div12_tc_count", 32'(tcs), 32'd2);
    chk("div12_q_at_end", 32'(bus.q), 32'h012);

    // BCD borrow ripple
    load(1'b1, W'('h100));
    count(1, 1'b1, W'('h100), tcs);
    chk("borrow_099", 32'(bus.q), 32'h099);
    load(1'b1, W'('h020));
    count(1, 1'b1, W'('h020), tcs);
    chk("borrow_019", 32'(bus.q), 32'h019);

    // one-shot
    load(1'b0, W'('h003));
    count(14, 1'b0, W'('h003), tcs);
    chk("oneshot_tc_count", 32'(tcs), 32'd1);
    chk("oneshot_zero", 32'(bus.zero), 32'h1);

    // inhibit mid-count, inhibit at q==1, preset beats inhibit
    load(1'b1, W'('h007));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, W'('h007));
    chk("inh_hold", 32'(bus.q), 32'h007);
    count(1, 1'b1, W'('h007), tcs);
    chk("inh_resume", 32'(bus.q), 32'h006);
    load(1'b1, W'('h002));
    count(1, 1'b1, W'('h002), tcs);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, W'('h002));
    chk("inh_defer_q", 32'(bus.q), 32'h001);
    count(1, 1'b1, W'('h002), tcs);
    chk("inh_defer_reload", 32'(tcs), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, W'('h045));
    chk("pe_over_inh", 32'(bus.q), 32'h045);

    // clamp
    load(1'b1, W'('h03C));
    chk("clamp_39", 32'(bus.q), 32'h039);
    load(1'b1, W'('hFAF));
    chk("clamp_999", 32'(bus.q), 32'h999);

    // divide by 5; sq is a 5-high/5-low square wave when present
    load(1'b1, W'('h005));
    sq_hi = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, W'('h005));
`ifdef LN4522_PRESCALER_SQUARE_EN
      if (bus.sq === 1'b1) sq_hi++;
`else
      if (bus.tc === 1'b1) sq_hi++;
`endif
    end
`ifdef LN4522_PRESCALER_SQUARE_EN
    chk("sq_duty", 32'(sq_hi), 32'd10);
`else
    chk("div5_tc_count", 32'(sq_hi), 32'd4);
`endif

    // random soak
    for (int i = 0; i < 1500; i++) begin
      rp = W'($urandom);
      if ($urandom_range(0, 1) == 0) rp = W'($urandom_range(0, 15));
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
